vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Stage directly downstream of the free-running 25 MHz horizontal pixel counter.
- Consumes that counter's 16-bit horizontal count and its once-per-line vertical-enable pulse.
- Maintains the vertical line counter and a vertical-region FSM.
- Produces registered hsync, vsync, video_on, pixel coordinates and a frame-start strobe for the pixel renderer and the VGA pins (640x480@60 timing).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_TOTAL, 800, pixels per line including blanking
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_TOTAL, 525, lines per frame
- HSYNC_POL, 0, asserted level of hsync (0 = active low)
- VSYNC_POL, 0, asserted level of vsync (0 = active low)

Ports:
- clk25MHz  input  1  pixel clock
- rst  input  1  asynchronous reset, active-high
- enableVertCount  input  1  one-cycle line pulse; high in the cycle horizontalCount==0
- horizontalCount  input  16  current pixel column from the horizontal counter
- hsync  output  1  horizontal sync to connector
- vsync  output  1  vertical sync to connector
- video_on  output  1  high when (pixel_x, pixel_y) is visible
- pixel_x  output  10  visible column, 0..H_ACTIVE-1; 0 when blanked
- pixel_y  output  10  current line, 0..V_TOTAL-1
- frame_start  output  1  one-cycle strobe on the first pixel of line 0
- timing_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - v_count=0 and the FSM is in V_ACT.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - video_on=0, pixel_x=0, pixel_y=0, frame_start=0, timing_err=0.
- Reset asserted mid-frame aborts the frame. After release, counting restarts at line 0 on the next enableVertCount.
- v_count (10 bits):
  - Updates only on an edge where enableVertCount=1.
  - v_next = (v_count==V_TOTAL-1) ? 0 : v_count+1.
  - Otherwise v_next = v_count.
- Vertical FSM, derived from v_next and updated on the same edge as v_count:
  - V_ACT: lines 0..V_ACTIVE-1
  - V_FP: lines V_ACTIVE..V_ACTIVE+V_FP-1
  - V_SYNC: lines up to V_ACTIVE+V_FP+V_SYNC-1
  - V_BP: remaining lines to V_TOTAL-1
  - Transitions: V_ACT->V_FP->V_SYNC->V_BP->V_ACT, one step per region boundary. No other transitions are legal.
- Output latency: all outputs are registered with exactly 1 clock of latency. Outputs after edge k reflect horizontalCount sampled at edge k and v_next.
- h_vis = horizontalCount < H_ACTIVE.
- hsync asserted iff H_ACTIVE+H_FP <= horizontalCount < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted iff state (next) == V_SYNC.
- video_on = h_vis && state (next) == V_ACT.
- pixel_x = h_vis ? horizontalCount[9:0] : 0.
- pixel_y = v_next.
- frame_start = enableVertCount && v_next==0 && horizontalCount==0.
- Wrap-around: line V_TOTAL-1 -> 0 puts the FSM in V_ACT and fires frame_start in the same registered cycle.
- Out-of-range horizontalCount >= H_TOTAL:
  - Treated as blank: video_on=0, hsync deasserted.
  - Sets timing_err.
- enableVertCount=1 while horizontalCount != 0:
  - v_count still advances.
  - Sets timing_err and suppresses frame_start.
- timing_err stays set until rst.
- enableVertCount held high for several consecutive cycles advances one line per cycle; no special handling.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480 default timing constants.
  - Typedef vstate_t {V_ACT, V_FP, V_SYNC, V_BP}.
  - Helper function for region lookup from a line number.
- One sub-module, vga_vert_counter, contains v_count, v_next and the FSM. It outputs v_next and the next state.
- The top module holds the output register stage and the error logic.

Test Plan:
- Reset check: assert rst mid-line 100 -> same cycle hsync=1, vsync=1, video_on=0, pixel_y=0. After release and 2 line pulses -> pixel_y=1.
- Full-frame scan: drive a model horizontal counter for 525 lines.
  - video_on count = 307200 per frame.
  - hsync low for 96 cycles per line, at columns 656..751 (+1 latency).
  - vsync low on lines 490..491 only.
- Wrap-around: pulse at line 524 -> next cycle pixel_y=0, frame_start=1 for exactly one cycle, FSM in V_ACT. frame_start fires once per 420000 clocks.
- Region edges: at line 479 col 639 -> video_on=1. Col 640 -> 0. Line 480 col 0 -> video_on=0, vsync still high.
- Bad horizontalCount: force horizontalCount=850 for one cycle -> video_on=0, hsync=1, timing_err=1 and it stays 1 after the return to normal input.
- Misaligned enable: enableVertCount=1 with horizontalCount=5 at line 524 -> pixel_y=0, frame_start=0, timing_err=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 timing constants, vertical region type and a
//               region lookup helper shared by the VGA sync generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int unsigned c_H_ACTIVE = 640;
    localparam int unsigned c_H_FP     = 16;
    localparam int unsigned c_H_SYNC   = 96;
    localparam int unsigned c_H_TOTAL  = 800;
    localparam int unsigned c_V_ACTIVE = 480;
    localparam int unsigned c_V_FP     = 10;
    localparam int unsigned c_V_SYNC   = 2;
    localparam int unsigned c_V_TOTAL  = 525;

    typedef enum logic [1:0] {
        V_ACT  = 2'd0,
        V_FP   = 2'd1,
        V_SYNC = 2'd2,
        V_BP   = 2'd3
    } vstate_t;

    // Vertical region that a given line number belongs to.
    function automatic vstate_t region_of(
        input logic [9:0]  line,
        input int unsigned act,
        input int unsigned fp,
        input int unsigned sync
    );
        vstate_t r;
        if (32'(line) < act)
            r = V_ACT;
        else if (32'(line) < act + fp)
            r = V_FP;
        else if (32'(line) < act + fp + sync)
            r = V_SYNC;
        else
            r = V_BP;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_vert_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_vert_counter
// Description : Line counter and vertical-region FSM. Exposes the line and
//               region that take effect on the current clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_vert_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned LINES_ACTIVE = c_V_ACTIVE,
    parameter int unsigned LINES_FP     = c_V_FP,
    parameter int unsigned LINES_SYNC   = c_V_SYNC,
    parameter int unsigned LINES_TOTAL  = c_V_TOTAL
) (
    input  logic       clk25MHz,
    input  logic       rst,
    input  logic       enableVertCount,
    output logic [9:0] v_next,
    output vstate_t    state_next
);

    localparam logic [9:0] c_LAST_LINE = 10'(LINES_TOTAL - 1);

    logic [9:0] r_v_count;
    logic       r_started;
    vstate_t    r_state;
    logic [9:0] w_v_next;
    vstate_t    w_state_next;

    // Line advance. The first pulse after reset lands on line 0 so an aborted
    // frame restarts cleanly; afterwards lines step by one and wrap.
    always_comb begin
        w_v_next = r_v_count;
        if (enableVertCount) begin
            if (!r_started || (r_v_count == c_LAST_LINE))
                w_v_next = '0;
            else
                w_v_next = r_v_count + 10'd1;
        end
    end

    // Region FSM: moves one region forward whenever the upcoming line leaves
    // the current region; the ring order is the only legal path.
    always_comb begin
        w_state_next = r_state;
        if (region_of(w_v_next, LINES_ACTIVE, LINES_FP, LINES_SYNC) != r_state) begin
            case (r_state)
                vga_timing_pkg::V_ACT:  w_state_next = vga_timing_pkg::V_FP;
                vga_timing_pkg::V_FP:   w_state_next = vga_timing_pkg::V_SYNC;
                vga_timing_pkg::V_SYNC: w_state_next = vga_timing_pkg::V_BP;
                default:                w_state_next = vga_timing_pkg::V_ACT;
            endcase
        end
    end

    // Line counter, restart flag and FSM state register.
    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            r_v_count <= '0;
            r_started <= 1'b0;
            r_state   <= vga_timing_pkg::V_ACT;
        end else begin
            r_v_count <= w_v_next;
            r_state   <= w_state_next;
            if (enableVertCount)
                r_started <= 1'b1;
        end
    end

    assign v_next     = w_v_next;
    assign state_next = w_state_next;

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : Registered VGA sync / blanking / coordinate generator fed by
//               the free-running horizontal pixel counter, with a sticky
//               protocol-violation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = c_H_ACTIVE,
    parameter int unsigned H_FP      = c_H_FP,
    parameter int unsigned H_SYNC    = c_H_SYNC,
    parameter int unsigned H_TOTAL   = c_H_TOTAL,
    parameter int unsigned V_ACTIVE  = c_V_ACTIVE,
    parameter int unsigned V_FP      = c_V_FP,
    parameter int unsigned V_SYNC    = c_V_SYNC,
    parameter int unsigned V_TOTAL   = c_V_TOTAL,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic        clk25MHz,
    input  logic        rst,
    input  logic        enableVertCount,
    input  logic [15:0] horizontalCount,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start,
    output logic        timing_err
);

    localparam logic [15:0] c_H_VIS_END = 16'(H_ACTIVE);
    localparam logic [15:0] c_HS_BEGIN  = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] c_HS_END    = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] c_H_LIMIT   = 16'(H_TOTAL);

    logic [9:0] w_v_next;
    vstate_t    w_state_next;
    logic       w_h_vis;
    logic       w_h_bad;
    logic       w_hs_on;
    logic       w_misaligned;
    logic       w_frame_start;

    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic [9:0] r_pixel_x;
    logic [9:0] r_pixel_y;
    logic       r_frame_start;
    logic       r_timing_err;

    vga_vert_counter #(
        .LINES_ACTIVE (V_ACTIVE),
        .LINES_FP     (V_FP),
        .LINES_SYNC   (V_SYNC),
        .LINES_TOTAL  (V_TOTAL)
    ) u_vert (
        .clk25MHz        (clk25MHz),
        .rst             (rst),
        .enableVertCount (enableVertCount),
        .v_next          (w_v_next),
        .state_next      (w_state_next)
    );

    // Out-of-range columns are blank and never drive hsync.
    assign w_h_vis       = horizontalCount < c_H_VIS_END;
    assign w_h_bad       = horizontalCount >= c_H_LIMIT;
    assign w_hs_on       = (horizontalCount >= c_HS_BEGIN) && (horizontalCount < c_HS_END) && !w_h_bad;
    assign w_misaligned  = enableVertCount && (horizontalCount != 16'd0);
    assign w_frame_start = enableVertCount && (w_v_next == 10'd0) && (horizontalCount == 16'd0);

    // Output stage: one clock of latency from the column and upcoming line.
    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_video_on    <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= (w_state_next == vga_timing_pkg::V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            r_video_on    <= w_h_vis && (w_state_next == vga_timing_pkg::V_ACT);
            r_pixel_x     <= w_h_vis ? horizontalCount[9:0] : 10'd0;
            r_pixel_y     <= w_v_next;
            r_frame_start <= w_frame_start;
        end
    end

    // Sticky violation flag: bad column or a line pulse off column 0.
    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst)
            r_timing_err <= 1'b0;
        else if (w_h_bad || w_misaligned)
            r_timing_err <= 1'b1;
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign frame_start = r_frame_start;
    assign timing_err  = r_timing_err;

endmodule
`default_nettype wire
